// File: rtl/alu_arbiter_if.sv
// Bundle for alu_arbiter: two requester ports, shared response bus and the
// ALU drive/return signals. The slave modport is the arbiter's view; the
// master modport is the view of the requesters plus the external ALU.
`timescale 1ns/1ps
interface alu_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 4
) ();
   logic                  req_valid_0;
   logic                  req_valid_1;
   logic                  req_ready_0;
   logic                  req_ready_1;
   logic [DATA_WIDTH-1:0] req_a_0;
   logic [DATA_WIDTH-1:0] req_a_1;
   logic [DATA_WIDTH-1:0] req_b_0;
   logic [DATA_WIDTH-1:0] req_b_1;
   logic [OP_WIDTH-1:0]   req_op_0;
   logic [OP_WIDTH-1:0]   req_op_1;
   logic                  resp_valid_0;
   logic                  resp_valid_1;
   logic                  resp_ready_0;
   logic                  resp_ready_1;
   logic [DATA_WIDTH-1:0] resp_result;
   logic                  resp_zero;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [OP_WIDTH-1:0]   alu_opcode;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_zero;

   modport slave (
      input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
             req_op_0, req_op_1, resp_ready_0, resp_ready_1, alu_result, alu_zero,
      output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
             resp_result, resp_zero, alu_a, alu_b, alu_opcode
   );

   modport master (
      output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
             req_op_0, req_op_1, resp_ready_0, resp_ready_1, alu_result, alu_zero,
      input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1,
             resp_result, resp_zero, alu_a, alu_b, alu_opcode
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between the
// execute stage (port 0) and the AGU/branch-compare unit (port 1).
// Issue register drives the ALU; a response register returns result/zero
// to the originating port. Optional performance counters: ALU_ARB_PERF_EN.
`timescale 1ns/1ps
module alu_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
`ifdef ALU_ARB_PERF_EN
   output logic [31:0] grant_cnt_0,
   output logic [31:0] grant_cnt_1,
   output logic [31:0] stall_cnt,
`endif
   alu_arbiter_if.slave bus
);

   localparam int unsigned CNT_WIDTH = 32;

   // Issue stage
   logic                  iss_valid_q, iss_valid_d;
   logic                  iss_id_q, iss_id_d;
   logic [DATA_WIDTH-1:0] iss_a_q, iss_a_d;
   logic [DATA_WIDTH-1:0] iss_b_q, iss_b_d;
   logic [OP_WIDTH-1:0]   iss_op_q, iss_op_d;
   // Response stage
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic                  rsp_zero_q, rsp_zero_d;
   // Arbitration history: 1 means port 0 wins the next tie
   logic                  last_grant_q, last_grant_d;

   logic rsp_free_c, iss_adv_c;
   logic grant_0_c, grant_1_c;
   logic ready_0_c, ready_1_c;
   logic accept_0_c, accept_1_c;

   // Stage availability, round-robin grant and request handshake
   always_comb begin
      rsp_free_c = !rsp_valid_q || (rsp_id_q ? bus.resp_ready_1 : bus.resp_ready_0);
      iss_adv_c  = !iss_valid_q || rsp_free_c;
      grant_0_c  = bus.req_valid_0 && (!bus.req_valid_1 || last_grant_q);
      grant_1_c  = bus.req_valid_1 && (!bus.req_valid_0 || !last_grant_q);
      ready_0_c  = grant_0_c && iss_adv_c && !rst;
      ready_1_c  = grant_1_c && iss_adv_c && !rst;
      accept_0_c = bus.req_valid_0 && ready_0_c;
      accept_1_c = bus.req_valid_1 && ready_1_c;
   end

   // Next-state for issue/response stages and grant history
   always_comb begin
      iss_valid_d  = iss_valid_q;
      iss_id_d     = iss_id_q;
      iss_a_d      = iss_a_q;
      iss_b_d      = iss_b_q;
      iss_op_d     = iss_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      last_grant_d = last_grant_q;

      if (iss_valid_q && rsp_free_c) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = iss_id_q;
         rsp_result_d = bus.alu_result;
         rsp_zero_d   = bus.alu_zero;
         iss_valid_d  = 1'b0;
      end else if (rsp_valid_q && rsp_free_c) begin
         rsp_valid_d  = 1'b0;
      end

      if (accept_0_c || accept_1_c) begin
         iss_valid_d  = 1'b1;
         iss_id_d     = accept_1_c;
         iss_a_d      = accept_1_c ? bus.req_a_1  : bus.req_a_0;
         iss_b_d      = accept_1_c ? bus.req_b_1  : bus.req_b_0;
         iss_op_d     = accept_1_c ? bus.req_op_1 : bus.req_op_0;
         last_grant_d = accept_1_c;
      end
   end

   // State registers, synchronous reset discards in-flight entries
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_valid_q  <= 1'b0;
         iss_id_q     <= 1'b0;
         iss_a_q      <= '0;
         iss_b_q      <= '0;
         iss_op_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         iss_valid_q  <= iss_valid_d;
         iss_id_q     <= iss_id_d;
         iss_a_q      <= iss_a_d;
         iss_b_q      <= iss_b_d;
         iss_op_q     <= iss_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.req_ready_0  = ready_0_c;
   assign bus.req_ready_1  = ready_1_c;
   assign bus.resp_valid_0 = rsp_valid_q && !rsp_id_q;
   assign bus.resp_valid_1 = rsp_valid_q && rsp_id_q;
   assign bus.resp_result  = rsp_result_q;
   assign bus.resp_zero    = rsp_zero_q;
   assign bus.alu_a        = iss_a_q;
   assign bus.alu_b        = iss_b_q;
   assign bus.alu_opcode   = iss_op_q;

`ifdef ALU_ARB_PERF_EN
   logic [CNT_WIDTH-1:0] grant_cnt_0_q, grant_cnt_1_q, stall_cnt_q;
   logic                 stall_c;

   assign stall_c = (bus.req_valid_0 || bus.req_valid_1) && !(ready_0_c || ready_1_c);

   // Accept and stall counters, wrapping at full scale
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_0_q <= '0;
         grant_cnt_1_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         if (accept_0_c) grant_cnt_0_q <= CNT_WIDTH'(grant_cnt_0_q + 1'b1);
         if (accept_1_c) grant_cnt_1_q <= CNT_WIDTH'(grant_cnt_1_q + 1'b1);
         if (stall_c)    stall_cnt_q   <= CNT_WIDTH'(stall_cnt_q + 1'b1);
      end
   end

   assign grant_cnt_0 = grant_cnt_0_q;
   assign grant_cnt_1 = grant_cnt_1_q;
   assign stall_cnt   = stall_cnt_q;
`else
   localparam int unsigned UNUSED_CNT_WIDTH = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by random traffic,
// checked by a transaction-level occupancy/round-robin model with a scoreboard.
`timescale 1ns/1ps
module tb_alu_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned OW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

`ifdef ALU_ARB_PERF_EN
   logic [31:0] gc0, gc1, sc;
`endif

   alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
      .clk(clk),
      .rst(rst),
`ifdef ALU_ARB_PERF_EN
      .grant_cnt_0(gc0),
      .grant_cnt_1(gc1),
      .stall_cnt(sc),
`endif
      .bus(bus)
   );

   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   // External combinational ALU
   always_comb begin
      bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);
      bus.alu_zero   = (bus.alu_result == '0);
   end

   typedef struct {
      bit              port;
      logic [DW-1:0]   res;
      bit              zero;
      int unsigned     edge_n;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   bit          prefer = 1'b0;
   bit          rst_prev = 1'b0;
   bit          prev_stall = 1'b0;
   logic [DW-1:0] prev_a, prev_b;
   logic [OW-1:0] prev_op;
   int          exp_g0 = 0, exp_g1 = 0, exp_st = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: compares DUT against the model, then advances the model
   always @(negedge clk) begin
      bit   vis, adv, g0, g1, cons, r0, r1;
      int   n;
      exp_t e;
      if (rst) begin
         chk("rst_req_ready_0", 64'(bus.req_ready_0), 64'd0);
         chk("rst_req_ready_1", 64'(bus.req_ready_1), 64'd0);
         if (rst_prev) begin
            chk("rst_resp_valid_0", 64'(bus.resp_valid_0), 64'd0);
            chk("rst_resp_valid_1", 64'(bus.resp_valid_1), 64'd0);
            chk("rst_resp_result", 64'(bus.resp_result), 64'd0);
            chk("rst_resp_zero", 64'(bus.resp_zero), 64'd0);
            chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
            chk("rst_alu_b", 64'(bus.alu_b), 64'd0);
            chk("rst_alu_opcode", 64'(bus.alu_opcode), 64'd0);
         end
         q.delete();
         prefer     = 1'b0;
         prev_stall = 1'b0;
         exp_g0 = 0; exp_g1 = 0; exp_st = 0;
      end else begin
         n   = q.size();
         vis = (n > 0) && (cyc >= q[0].edge_n + 1);
         chk("resp_valid_0", 64'(bus.resp_valid_0), 64'(vis && !q[0].port));
         chk("resp_valid_1", 64'(bus.resp_valid_1), 64'(vis && q[0].port));
         if (vis) begin
            chk("resp_result", 64'(bus.resp_result), 64'(q[0].res));
            chk("resp_zero", 64'(bus.resp_zero), 64'(q[0].zero));
         end
         cons = vis && (q[0].port ? bus.resp_ready_1 : bus.resp_ready_0);
         adv  = (n < 2) || cons;
         g0   = bus.req_valid_0 && (!bus.req_valid_1 || prefer == 1'b0);
         g1   = bus.req_valid_1 && (!bus.req_valid_0 || prefer == 1'b1);
         r0   = g0 && adv;
         r1   = g1 && adv;
         chk("req_ready_0", 64'(bus.req_ready_0), 64'(r0));
         chk("req_ready_1", 64'(bus.req_ready_1), 64'(r1));
         if (prev_stall) begin
            chk("stall_alu_a", 64'(bus.alu_a), 64'(prev_a));
            chk("stall_alu_b", 64'(bus.alu_b), 64'(prev_b));
            chk("stall_alu_opcode", 64'(bus.alu_opcode), 64'(prev_op));
         end
         prev_stall = (n == 2) && !adv;
         prev_a  = bus.alu_a;
         prev_b  = bus.alu_b;
         prev_op = bus.alu_opcode;
         if (cons) void'(q.pop_front());
         if (r0 || r1) begin
            e.port   = r1;
            e.res    = r1 ? alu_f(bus.req_a_1, bus.req_b_1, bus.req_op_1)
                          : alu_f(bus.req_a_0, bus.req_b_0, bus.req_op_0);
            e.zero   = (e.res == '0);
            e.edge_n = cyc + 1;
            q.push_back(e);
            prefer = !r1;
            if (r1) exp_g1++; else exp_g0++;
         end else if (bus.req_valid_0 || bus.req_valid_1) begin
            exp_st++;
         end
      end
      rst_prev = rst;
   end

   task automatic drive(input bit v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                        input logic [OW-1:0] op0, input bit v1, input logic [DW-1:0] a1,
                        input logic [DW-1:0] b1, input logic [OW-1:0] op1,
                        input bit rr0, input bit rr1, input int ncyc);
      bus.req_valid_0 = v0; bus.req_a_0 = a0; bus.req_b_0 = b0; bus.req_op_0 = op0;
      bus.req_valid_1 = v1; bus.req_a_1 = a1; bus.req_b_1 = b1; bus.req_op_1 = op1;
      bus.resp_ready_0 = rr0; bus.resp_ready_1 = rr1;
      repeat (ncyc) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int ncyc);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ncyc);
   endtask

   function automatic logic [DW-1:0] rnd_opnd();
      if ($urandom_range(0, 1) == 0) return DW'($urandom_range(0, 3));
      return DW'($urandom());
   endfunction

   initial begin
      rst = 1'b1;
      drive(1, 1, 1, 0, 1, 2, 2, 0, 0, 0, 3);
      rst = 1'b0;
      // Single request on port 0: 5 + 10
      drive(1, 5, 10, 0, 0, 0, 0, 0, 1, 1, 1);
      idle(3);
      // Both ports contending continuously
      drive(1, 20, 6, 1, 1, 7, 7, 1, 1, 1, 6);
      idle(3);
      // Port 0 response backpressured for several cycles
      drive(1, 5, 10, 0, 1, 7, 7, 0, 0, 1, 5);
      idle(4);
      // Back-to-back on port 1
      drive(0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1);
      drive(0, 0, 0, 0, 1, 2, 2, 0, 1, 1, 1);
      drive(0, 0, 0, 0, 1, 3, 3, 0, 1, 1, 1);
      drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1);
      idle(3);
      // Fill both stages, reset, then contend
      drive(1, 9, 4, 1, 1, 8, 8, 1, 0, 0, 3);
      rst = 1'b1;
      drive(1, 9, 4, 1, 1, 8, 8, 1, 0, 0, 2);
      rst = 1'b0;
      drive(1, 3, 4, 0, 1, 5, 6, 0, 1, 1, 1);
      idle(3);
      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if (i == 200) rst = 1'b1;
         else          rst = 1'b0;
         drive(bit'($urandom_range(0, 99) < 60), rnd_opnd(), rnd_opnd(), OW'($urandom_range(0, 5)),
               bit'($urandom_range(0, 99) < 60), rnd_opnd(), rnd_opnd(), OW'($urandom_range(0, 5)),
               bit'($urandom_range(0, 99) < 70), bit'($urandom_range(0, 99) < 70), 1);
      end
      rst = 1'b0;
      idle(10);
      chk("drain_empty", 64'(q.size()), 64'd0);
`ifdef ALU_ARB_PERF_EN
      chk("grant_cnt_0", 64'(gc0), 64'(exp_g0));
      chk("grant_cnt_1", 64'(gc1), 64'(exp_g1));
      chk("stall_cnt", 64'(sc), 64'(exp_st));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the integer pipeline execute stage, port 1 is the address-generation/branch-compare unit.
- Performs round-robin arbitration with a valid/ready handshake.
- Registers the winning operands into an issue stage that drives the ALU.
- Captures the ALU result and zero flag into a response register and routes them back to the originating port.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OP_WIDTH, 4, ALU opcode width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid_0 / req_valid_1  input  1  request present on port 0 / 1.
- req_ready_0 / req_ready_1  output  1  request accepted this cycle.
- req_a_0 / req_a_1  input  DATA_WIDTH  operand a.
- req_b_0 / req_b_1  input  DATA_WIDTH  operand b.
- req_op_0 / req_op_1  input  OP_WIDTH  ALU opcode.
- resp_valid_0 / resp_valid_1  output  1  response available to port 0 / 1.
- resp_ready_0 / resp_ready_1  input  1  port consumes its response.
- resp_result  output  DATA_WIDTH  shared result bus, meaningful only with a resp_valid_x.
- resp_zero  output  1  shared zero flag.
- alu_a, alu_b  output  DATA_WIDTH  to ALU a/b.
- alu_opcode  output  OP_WIDTH  to ALU opcode.
- alu_result  input  DATA_WIDTH  from ALU result.
- alu_zero  input  1  from ALU zero.

Behaviour:
- Clock and reset are fixed as one clock, clk; reset rst is synchronous, active-high.
- State registers:
  - Issue stage: iss_valid, iss_id, a, b, op.
  - Response stage: rsp_valid, rsp_id, result, zero.
  - last_grant: 1 bit.
- Reset values:
  - iss_valid = 0, rsp_valid = 0, last_grant = 1 (port 0 wins first tie).
  - All resp_valid_x = 0, all req_ready_x = 0.
  - resp_result = 0, resp_zero = 0, alu_a = alu_b = 0, alu_opcode = 0.
- ALU drive: alu_a, alu_b and alu_opcode come straight from the issue registers.
- Stage movement:
  - rsp_free = !rsp_valid || (resp_ready of rsp_id port).
  - iss_adv = !iss_valid || rsp_free.
- Grant:
  - Only one valid request: that port wins.
  - Both valid: the port != last_grant wins.
  - Neither valid: no grant.
- Handshake: req_ready_x = grant_x && iss_adv. This is combinational on req_valid_*; requesters must not make req_valid depend on req_ready.
- Accept (req_valid_x && req_ready_x at an edge):
  - Load the issue stage with port x operands, set iss_id = x, iss_valid = 1.
  - Set last_grant = x.
- When iss_valid and rsp_free at an edge:
  - Response stage loads alu_result, alu_zero and iss_id; rsp_valid = 1.
  - iss_valid clears unless a new accept occurs in the same edge.
- Response: resp_valid_x = rsp_valid && rsp_id == x. The response is held stable until the matching resp_ready_x is sampled high.
- rsp_valid clears on consume unless a new result loads in the same edge.
- Latency: accept at edge N, resp_valid high after edge N+1. Throughput is 1 op/cycle when resp_ready is held high.
- Backpressure: if the response is not consumed, the issue stage holds, req_ready drops to 0 and the ALU inputs stay stable.
- Responses are in order; no reordering or dropping.
- last_grant updates only on accept, never on a mere request.
- resp_ready_x for a port whose resp_valid_x is 0 is ignored.
- Reset mid-operation: in-flight issue/response entries are discarded and no response is produced for them.
- Arithmetic: none internal; width follows DATA_WIDTH.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds outputs grant_cnt_0 and grant_cnt_1 (32 bit each) and stall_cnt (32 bit).
  - grant_cnt_x increments on each port-x accept.
  - stall_cnt increments each cycle any req_valid is high but no req_ready is high.
  - All counters reset to 0 and wrap 0xFFFFFFFF -> 0.
- Undefined: these ports and registers do not exist; functionality is otherwise identical.

Test Plan:
- Reset, then port 0 only: a=5, b=10, op=0000, resp_ready high.
  -> req_ready_0 high in that cycle.
  -> resp_valid_0 = 1 after 2 edges with resp_result = 15, resp_zero = 0; resp_valid_1 stays 0.
- Both ports valid continuously: port0 20-6 (op 0001), port1 7-7 (op 0001).
  -> grants alternate 0,1,0,1.
  -> responses 14 (zero 0) to port 0 and 0 (zero 1) to port 1, in grant order.
- Response backpressure: resp_ready_0 low for 3 cycles after the first response.
  -> resp_result held at 15.
  -> req_ready_* = 0 once the issue stage is full.
  -> alu_a/alu_b unchanged.
  -> releasing resp_ready drains both results in order.
- Back-to-back on port 1, 4 requests (op 0000): (1,1), (2,2), (3,3), (0,0) with resp_ready high.
  -> 4 accepts in 4 cycles, results 2, 4, 6, 0.
  -> resp_zero high only on the last.
- Assert rst while both stages are full.
  -> next cycle all resp_valid = 0 and req_ready = 0 for one cycle.
  -> the next simultaneous request is granted to port 0.
- With ALU_ARB_PERF_EN: 3 port-0 accepts and 2 port-1 accepts, plus 2 backpressure cycles with a request pending.
  -> grant_cnt_0 = 3, grant_cnt_1 = 2, stall_cnt = 2.
  -> preload near-wrap via long run: 0xFFFFFFFF + 1 -> 0.
